// File: rtl/npc_bpred.sv
`default_nettype none
// ---------------------------------------------------------------------------
// npc_bpred : fetch PC register + direct-mapped BTB with 2-bit counters
// Rev 1.0
// ---------------------------------------------------------------------------
module npc_bpred #(
  parameter int                 ADDR_W   = 32,
  parameter int                 ENTRIES  = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_3000,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic              upd_is_branch,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              flush,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [ADDR_W-1:0]  target_mem [ENTRIES];
  logic [1:0]         cnt_mem    [ENTRIES];

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;
  logic [ADDR_W-1:0] pc_plus4;
  logic [IDX_W-1:0]  up_idx;
  logic [TAG_W-1:0]  up_tag;
  logic              up_hit;
  logic              up_br;
  logic              mis;

  assign lk_idx   = pc[IDX_W+1:2];
  assign lk_tag   = pc[ADDR_W-1:IDX_W+2];
  assign lk_hit   = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign pc_plus4 = pc + ADDR_W'(4);

  assign pred_taken  = lk_hit && cnt_mem[lk_idx][1];
  assign pred_target = pred_taken ? target_mem[lk_idx] : pc_plus4;

  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign up_hit = valid[up_idx] && (tag_mem[up_idx] == up_tag);
  assign up_br  = upd_valid && upd_is_branch;

  assign mis   = up_br && ((upd_taken != upd_pred_taken) ||
                           (upd_taken && (upd_target != upd_pred_target)));
  assign flush = mis;

  // A redirect outranks a stall: the stalled fetch is on the wrong path anyway.
  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else if (mis)
      pc <= upd_taken ? upd_target : (upd_pc + ADDR_W'(4));
    else if (!stall)
      pc <= pred_target;
  end

  always_ff @(posedge clk) begin
    if (rst)
      valid <= '0;
    else if (up_br && upd_taken && !up_hit)
      valid[up_idx] <= 1'b1;
  end

  // Payload arrays carry no reset; they are ignored while the entry is invalid.
  always_ff @(posedge clk) begin
    if (!rst && up_br) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (cnt_mem[up_idx] != 2'b11)
            cnt_mem[up_idx] <= cnt_mem[up_idx] + 2'd1;
          target_mem[up_idx] <= upd_target;
        end else if (cnt_mem[up_idx] != 2'b00) begin
          cnt_mem[up_idx] <= cnt_mem[up_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        tag_mem[up_idx]    <= up_tag;
        target_mem[up_idx] <= upd_target;
        cnt_mem[up_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      mispred_cnt <= '0;
    else if (mis && (mispred_cnt != {CNT_W{1'b1}}))
      mispred_cnt <= mispred_cnt + CNT_W'(1);
  end

endmodule
`default_nettype wire

// File: tb/tb_npc_bpred.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_npc_bpred : directed + randomized bench against a behavioural BTB model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_npc_bpred;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic        upd_valid, upd_is_branch, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic [31:0] pc, pred_target;
  logic        pred_taken, flush;
  logic [15:0] mispred_cnt;
  logic [31:0] s_pc, s_pred_target;
  logic        s_pred_taken, s_flush;
  logic [3:0]  s_mispred_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  npc_bpred u_dut (
    .clk(clk), .rst(rst), .stall(stall), .pc(pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .upd_valid(upd_valid), .upd_is_branch(upd_is_branch),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .flush(flush), .mispred_cnt(mispred_cnt)
  );

  npc_bpred #(.ENTRIES(4), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .stall(stall), .pc(s_pc), .pred_taken(s_pred_taken),
    .pred_target(s_pred_target), .upd_valid(upd_valid), .upd_is_branch(upd_is_branch),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .flush(s_flush), .mispred_cnt(s_mispred_cnt)
  );

  // Behavioural model of the 16-entry instance
  int unsigned m_pc;
  bit          m_v   [16];
  int unsigned m_tag [16];
  int unsigned m_tgt [16];
  int          m_ctr [16];
  int unsigned m_mc, m_mc4;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  function automatic void m_lookup(input int unsigned a, output bit tk, output int unsigned tg);
    int unsigned i = (a >> 2) % 16;
    bit hit = m_v[i] && (m_tag[i] == (a >> 6));
    tk = hit && (m_ctr[i] >= 2);
    tg = tk ? m_tgt[i] : a + 4;
  endfunction

  function automatic bit m_mis();
    return upd_valid && upd_is_branch &&
           ((upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target));
  endfunction

  task automatic idle();
    rst = 0; stall = 0; upd_valid = 0; upd_is_branch = 0; upd_taken = 0;
    upd_pred_taken = 0; upd_pc = 0; upd_target = 0; upd_pred_target = 0;
  endtask

  task automatic upd(input logic [31:0] a, input bit tk, input logic [31:0] tg,
                     input bit ptk, input logic [31:0] ptg);
    upd_valid = 1; upd_is_branch = 1; upd_pc = a; upd_taken = tk;
    upd_target = tg; upd_pred_taken = ptk; upd_pred_target = ptg;
  endtask

  // Inputs are already applied; compare every output with the model.
  task automatic drive_check();
    bit tk; int unsigned tg;
    #1;
    m_lookup(m_pc, tk, tg);
    check("pc", 64'(pc), 64'(m_pc));
    check("pred_taken", 64'(pred_taken), 64'(tk));
    check("pred_target", 64'(pred_target), 64'(tg));
    check("flush", 64'(flush), 64'(m_mis()));
    check("mispred_cnt", 64'(mispred_cnt), 64'(m_mc));
    check("flush_small", 64'(s_flush), 64'(m_mis()));
    check("mispred_cnt_small", 64'(s_mispred_cnt), 64'(m_mc4));
  endtask

  task automatic tick();
    bit mis = m_mis();
    bit tk; int unsigned tg, i;
    m_lookup(m_pc, tk, tg);
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h3000; m_mc = 0; m_mc4 = 0;
      foreach (m_v[k]) m_v[k] = 0;
    end else begin
      if (mis) m_pc = upd_taken ? upd_target : upd_pc + 4;
      else if (!stall) m_pc = tg;
      if (upd_valid && upd_is_branch) begin
        i = (upd_pc >> 2) % 16;
        if (m_v[i] && m_tag[i] == (upd_pc >> 6)) begin
          if (upd_taken) begin
            m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            m_tgt[i] = upd_target;
          end else begin
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
          end
        end else if (upd_taken) begin
          m_v[i] = 1; m_tag[i] = upd_pc >> 6; m_tgt[i] = upd_target; m_ctr[i] = 2;
        end
      end
      if (mis) begin
        if (m_mc < 65535) m_mc++;
        if (m_mc4 < 15) m_mc4++;
      end
    end
    #1;
  endtask

  // One full cycle with the currently applied inputs.
  task automatic cyc();
    drive_check();
    tick();
  endtask

  function automatic logic [31:0] pool_addr();
    return 32'h3000 + 32'(4 * $urandom_range(0, 63));
  endfunction

  initial begin
    idle(); rst = 1;
    tick();

    // Reset state and sequential fetch
    idle(); rst = 1; cyc();
    idle();
    drive_check();
    check("plan1_pc0", 64'(pc), 64'h3000);
    check("plan1_cnt0", 64'(mispred_cnt), 64'h0);
    tick();
    cyc(); cyc();
    drive_check();
    check("plan1_pc3", 64'(pc), 64'h300C);
    check("plan1_pt3", 64'(pred_taken), 64'h0);
    tick();

    // Taken mispredict allocates and redirects
    upd(32'h3010, 1, 32'h3040, 0, 32'h3014);
    drive_check();
    check("plan2_flush", 64'(flush), 64'h1);
    tick();
    idle();
    drive_check();
    check("plan2_pc", 64'(pc), 64'h3040);
    check("plan2_cnt", 64'(mispred_cnt), 64'h1);
    tick();
    upd(32'h3100, 1, 32'h3010, 0, 32'h3104); cyc();
    idle();
    drive_check();
    check("plan2_pt", 64'(pred_taken), 64'h1);
    check("plan2_ptg", 64'(pred_target), 64'h3040);
    tick();

    // Two not-taken updates walk the counter down
    upd(32'h3010, 0, 32'h3040, 1, 32'h3040); cyc();
    upd(32'h300C, 1, 32'h3010, 0, 32'h3010); cyc();
    idle();
    drive_check();
    check("plan3_pt", 64'(pred_taken), 64'h0);
    check("plan3_ptg", 64'(pred_target), 64'h3014);
    tick();
    upd(32'h3010, 0, 32'h3040, 1, 32'h3040);
    drive_check();
    check("plan3_flush2", 64'(flush), 64'h1);
    tick();

    // Alias at the same index, different tag
    upd(32'h3010, 1, 32'h3040, 1, 32'h3040); cyc();
    upd(32'h3010, 1, 32'h3050, 1, 32'h3040); cyc();
    idle();
    drive_check();
    check("plan4_pc", 64'(pc), 64'h3050);
    check("plan4_pt", 64'(pred_taken), 64'h0);
    check("plan4_ptg", 64'(pred_target), 64'h3054);
    tick();

    // Redirect overrides stall; a correct resolution under stall holds pc
    idle(); stall = 1; upd(32'h3020, 0, 32'h3090, 1, 32'h3090); cyc();
    idle(); stall = 1; upd(32'h3020, 0, 32'h0, 0, 32'h3024);
    drive_check();
    check("plan5_pc", 64'(pc), 64'h3024);
    check("plan5_noflush", 64'(flush), 64'h0);
    tick();
    idle(); stall = 1;
    drive_check();
    check("plan5_hold", 64'(pc), 64'h3024);
    tick();

    // Reset discards a simultaneous update
    idle(); rst = 1; upd(32'h3080, 1, 32'h30C0, 0, 32'h3084);
    drive_check();
    check("plan6_flush_in_rst", 64'(flush), 64'h1);
    tick();
    idle();
    drive_check();
    check("plan6_pc", 64'(pc), 64'h3000);
    check("plan6_cnt", 64'(mispred_cnt), 64'h0);
    tick();
    upd(32'h3000, 1, 32'h3080, 0, 32'h3004); cyc();
    idle();
    drive_check();
    check("plan6_miss", 64'(pred_taken), 64'h0);
    tick();

    // Small counter saturation
    for (int k = 0; k < 18; k++) begin
      idle(); stall = 1; upd(32'h3200, 0, 32'h0, 1, 32'h0); cyc();
    end
    idle();
    drive_check();
    check("sat_small", 64'(s_mispred_cnt), 64'hF);
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit tk; int unsigned tg;
      idle();
      rst   = ($urandom_range(0, 199) == 0);
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) != 0) begin
        upd_valid     = 1;
        upd_is_branch = ($urandom_range(0, 4) != 0);
        upd_pc        = pool_addr();
        upd_taken     = $urandom_range(0, 1);
        upd_target    = pool_addr();
        if ($urandom_range(0, 1) != 0) begin
          m_lookup(upd_pc, tk, tg);
          upd_pred_taken  = tk;
          upd_pred_target = tg;
        end else begin
          upd_pred_taken  = $urandom_range(0, 1);
          upd_pred_target = pool_addr();
        end
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/npc_bpred.md
Name: npc_bpred

Overview:
- Parametrised next-PC generator for the pipelined core; adds branch prediction at fetch.
- Owns the fetch PC register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Predicts the next PC in the same cycle as fetch; EX-stage resolution writes back into the BTB and redirects on a mispredict.
- Also keeps a saturating mispredict counter for performance measurement.

Parameters:
- ADDR_W, 32: PC/target width in bits.
- ENTRIES, 16: BTB entries; power of 2, >=2. IDX_W = log2(ENTRIES).
- RESET_PC, 32'h0000_3000: fetch PC after reset.
- CNT_W, 16: width of the mispredict counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold fetch PC (pipeline stall)
- pc  out  ADDR_W  current fetch PC (registered)
- pred_taken  out  1  fetch-stage prediction for pc
- pred_target  out  ADDR_W  predicted next PC for pc
- upd_valid  in  1  EX resolution valid this cycle
- upd_is_branch  in  1  resolved instruction is a branch/jump
- upd_pc  in  ADDR_W  PC of the resolved instruction
- upd_taken  in  1  actual direction
- upd_target  in  ADDR_W  actual taken target
- upd_pred_taken  in  1  prediction carried down the pipe for upd_pc
- upd_pred_target  in  ADDR_W  predicted next PC carried down the pipe
- flush  out  1  mispredict; squash younger instructions (combinational)
- mispred_cnt  out  CNT_W  mispredicts since reset

Behaviour:
- Indexing: idx = addr[IDX_W+1:2]; tag = addr[ADDR_W-1:IDX_W+2]. addr[1:0] is ignored.
- Entry contents: valid, tag, target[ADDR_W], cnt[1:0].
- Lookup (combinational on pc):
  - hit = valid[idx] && tag match.
  - pred_taken = hit && cnt[1].
  - pred_target = pred_taken ? target : pc+4.
  - pc+4 wraps modulo 2^ADDR_W.
- Mispredict:
  - mis = upd_valid && upd_is_branch && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
  - flush = mis, in the same cycle.
  - A non-branch resolution never flushes.
- Next-PC priority at each edge (highest first):
  1. rst: pc <= RESET_PC.
  2. mis: pc <= upd_taken ? upd_target : upd_pc+4. Applies even when stall=1.
  3. stall: pc holds.
  4. Otherwise: pc <= pred_target.
- BTB update on upd_valid && upd_is_branch, at the clock edge:
  - Hit at upd_pc, taken: cnt saturating +1 (max 2'b11); target <= upd_target.
  - Hit at upd_pc, not taken: cnt saturating -1 (min 2'b00); target is unchanged.
  - Miss, taken: allocate/overwrite the entry; valid=1, tag=upd tag, target=upd_target, cnt=2'b10.
  - Miss, not taken: no change.
- Read/write ordering: a lookup and an update to the same idx in the same cycle return the pre-update contents. There is no bypass.
- mispred_cnt increments by 1 on each cycle with mis=1 and saturates at all-ones.
- Reset:
  - Clears all valid bits and mispred_cnt; pc = RESET_PC.
  - Counters and targets are don't-care while valid=0.
  - Reset during an update cycle discards the update.
  - flush is still driven combinationally from the inputs during reset.
- Latency:
  - Prediction: 0 cycles (combinational from pc).
  - Redirect: the new pc is visible 1 cycle after the mis cycle.

Test Plan:
1. Reset, then 3 cycles with stall=0 and no updates -> pc 0x3000, 0x3004, 0x3008, 0x300C; pred_taken=0; flush=0; mispred_cnt=0.
2. upd at 0x3010 (upd_taken=1, upd_target=0x3040, upd_pred_taken=0) -> same cycle flush=1; next pc=0x3040; mispred_cnt=1. Later pc=0x3010 -> pred_taken=1, pred_target=0x3040.
3. Two not-taken updates at 0x3010, predicted taken -> cnt 10->01->00. After the first update, a lookup of 0x3010 gives pred_taken=0, pred_target=0x3014. Both updates flush; mispred_cnt +2.
4. Alias: with entry idx 4 allocated for 0x3010, pc=0x3050 (same idx, different tag) -> pred_taken=0, pred_target=0x3054.
5. stall=1 with a simultaneous mis (upd_taken=0, upd_pc=0x3020) -> pc=0x3024 next cycle, i.e. the redirect overrides the stall. A correct prediction with stall=1 -> pc holds and flush=0.
6. rst asserted in the same cycle as a taken update and a mis -> pc=0x3000, mispred_cnt=0, BTB all invalid (a lookup of upd_pc misses). Also: mispred_cnt forced near all-ones (CNT_W=4 variant) saturates at 0xF.
